// File: rtl/ram_pulse_ctrl.sv
// ram_pulse_ctrl
//   Control stage behind the button one-shot conditioner. Each pulse[0]
//   steps the RAM address. Each pulse[1] writes the captured switch value to
//   the current address and then reads it back. The block also keeps a
//   per-location valid mask and a count of how many locations have been
//   written.
//
// Ports
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   pulse    in   [0]=step address, [1]=write din (single-cycle pulses)
//   din      in   write data, sampled only when a write pulse is accepted
//   addr     out  current RAM address
//   dout     out  registered read data for addr (0 if never written)
//   busy     out  write sequence in progress
//   wr_done  out  one-cycle pulse at the end of a write sequence
//   count    out  number of distinct locations written since reset
//   full     out  every location has been written
//
// Build option
//   RAM_AUTO_INC_EN : advance addr by one at the end of each write sequence.
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | accept step/write pulses, refresh dout from the RAM
// WR    | commit wdata to mem[addr], set valid, bump count if new
// RD    | read back the written value, pulse wr_done

module ram_pulse_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [1:0]    pulse,
    input  logic [DW-1:0] din,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          wr_done,
    output logic [AW:0]   count,
    output logic          full
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t           state;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DW-1:0]    wdata;

    // The array has no reset. After a reset the cleared valid mask hides
    // whatever contents were left behind. Reset forces the state to IDLE
    // right away, so a reset during WR cannot commit a write afterwards.
    always_ff @(posedge clk) begin
        if (state == WR) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            addr    <= '0;
            dout    <= '0;
            wr_done <= 1'b0;
            valid   <= '0;
            count   <= '0;
            wdata   <= '0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    dout <= valid[addr] ? mem[addr] : '0;
                    // A write takes priority over a step that arrives in the same cycle.
                    if (pulse[1]) begin
                        wdata <= din;
                        state <= WR;
                    end else if (pulse[0]) begin
                        addr <= addr + 1'b1;
                    end
                end
                WR: begin
                    valid[addr] <= 1'b1;
                    // Only a location written for the first time adds to count,
                    // so count stops at DEPTH on its own.
                    if (!valid[addr]) begin
                        count <= count + 1'b1;
                    end
                    state <= RD;
                end
                RD: begin
                    dout    <= mem[addr];
                    wr_done <= 1'b1;
                    state   <= IDLE;
`ifdef RAM_AUTO_INC_EN
                    addr    <= addr + 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign full = (count == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_ram_pulse_ctrl.sv
module tb_ram_pulse_ctrl;

    logic       clk;
    logic       clr_n;
    logic [1:0] pulse;
    logic [7:0] din;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       busy;
    logic       wr_done;
    logic [4:0] count;
    logic       full;

    int pass_cnt;
    int total_cnt;

    // reference scoreboard
    logic [7:0] exp_mem [16];
    logic       exp_valid [16];
    logic [3:0] exp_addr;
    logic [4:0] exp_count;

    ram_pulse_ctrl #(.AW(4), .DW(8)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .pulse   (pulse),
        .din     (din),
        .addr    (addr),
        .dout    (dout),
        .busy    (busy),
        .wr_done (wr_done),
        .count   (count),
        .full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
        return exp_valid[a] ? exp_mem[a] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_valid[i] = 1'b0;
        exp_addr  = 4'd0;
        exp_count = 5'd0;
    endtask

    task automatic model_write(input logic [7:0] d);
        if (!exp_valid[exp_addr]) exp_count = exp_count + 5'd1;
        exp_valid[exp_addr] = 1'b1;
        exp_mem[exp_addr]   = d;
`ifdef RAM_AUTO_INC_EN
        exp_addr = exp_addr + 4'd1;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clr_n = 1'b0;
        pulse = 2'b00;
        din   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        pulse = 2'b01;
        tick();
        pulse = 2'b00;
        exp_addr = exp_addr + 4'd1;
    endtask

    task automatic goto_addr(input logic [3:0] a);
        for (int i = 0; i < 16 && exp_addr != a; i++) step();
        tick();
    endtask

    // Ends on the edge that produces readback and wr_done (N+2).
    task automatic write_seq(input logic [7:0] d);
        din   = d;
        pulse = 2'b10;
        tick();
        pulse = 2'b00;
        din   = ~d;
        tick();
        tick();
        model_write(d);
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (5) tick();
        total_cnt++; if (addr !== 4'd0) $display("FAIL rst_addr: got %0h exp 0", addr); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL rst_dout: got %0h exp 0", dout); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL rst_count: got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL rst_full: got %0b exp 0", full); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b exp 0", busy); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL rst_wr_done: got %0b exp 0", wr_done); else pass_cnt++;
    endtask

    task automatic test_write_timing();
        din   = 8'hA5;
        pulse = 2'b10;
        tick();
        pulse = 2'b00;
        din   = 8'hFF;
        total_cnt++; if (busy !== 1'b1) $display("FAIL wt_busy_n: got %0b exp 1", busy); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL wt_done_n: got %0b exp 0", wr_done); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL wt_busy_n1: got %0b exp 1", busy); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL wt_done_n1: got %0b exp 0", wr_done); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL wt_count_n1: got %0d exp 1", count); else pass_cnt++;
        tick();
        model_write(8'hA5);
        total_cnt++; if (busy !== 1'b0) $display("FAIL wt_busy_n2: got %0b exp 0", busy); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b1) $display("FAIL wt_done_n2: got %0b exp 1", wr_done); else pass_cnt++;
        total_cnt++; if (dout !== 8'hA5) $display("FAIL wt_dout_n2: got %0h exp a5", dout); else pass_cnt++;
        total_cnt++; if (addr !== exp_addr) $display("FAIL wt_addr_n2: got %0h exp %0h", addr, exp_addr); else pass_cnt++;
        tick();
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL wt_done_n3: got %0b exp 0", wr_done); else pass_cnt++;
        total_cnt++; if (dout !== exp_rd(exp_addr)) $display("FAIL wt_dout_n3: got %0h exp %0h", dout, exp_rd(exp_addr)); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL wt_full: got %0b exp 0", full); else pass_cnt++;
    endtask

    task automatic test_step_wrap();
        goto_addr(4'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            tick();
            total_cnt++; if (addr !== exp_addr) $display("FAIL step_addr[%0d]: got %0h exp %0h", i, addr, exp_addr); else pass_cnt++;
            total_cnt++; if (dout !== exp_rd(exp_addr)) $display("FAIL step_dout[%0d]: got %0h exp %0h", i, dout, exp_rd(exp_addr)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (addr !== 4'd0) $display("FAIL step_wrap_addr: got %0h exp 0", addr); else pass_cnt++;
        total_cnt++; if (dout !== 8'hA5) $display("FAIL step_wrap_dout: got %0h exp a5", dout); else pass_cnt++;
    endtask

    task automatic test_overwrite_fill();
        goto_addr(4'd0);
        write_seq(8'h3C);
        total_cnt++; if (dout !== 8'h3C) $display("FAIL ow_dout: got %0h exp 3c", dout); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL ow_count: got %0d exp 1", count); else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            goto_addr(4'(a));
            write_seq(8'h40 + 8'(a));
            total_cnt++; if (dout !== 8'h40 + 8'(a)) $display("FAIL fill_dout[%0d]: got %0h exp %0h", a, dout, 8'h40 + 8'(a)); else pass_cnt++;
            total_cnt++; if (count !== exp_count) $display("FAIL fill_count[%0d]: got %0d exp %0d", a, count, exp_count); else pass_cnt++;
            total_cnt++; if (full !== (exp_count == 5'd16)) $display("FAIL fill_full[%0d]: got %0b exp %0b", a, full, exp_count == 5'd16); else pass_cnt++;
        end
        total_cnt++; if (count !== 5'd16) $display("FAIL fill_final_count: got %0d exp 16", count); else pass_cnt++;
        total_cnt++; if (full !== 1'b1) $display("FAIL fill_final_full: got %0b exp 1", full); else pass_cnt++;
        goto_addr(4'd7);
        write_seq(8'hEE);
        total_cnt++; if (dout !== 8'hEE) $display("FAIL full_ow_dout: got %0h exp ee", dout); else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL full_ow_count: got %0d exp 16", count); else pass_cnt++;
        total_cnt++; if (full !== 1'b1) $display("FAIL full_ow_full: got %0b exp 1", full); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        goto_addr(4'd5);
        din   = 8'h11;
        pulse = 2'b11;
        tick();
        pulse = 2'b10;
        din   = 8'h99;
        tick();
        pulse = 2'b01;
        tick();
        pulse = 2'b00;
        model_write(8'h11);
        total_cnt++; if (wr_done !== 1'b1) $display("FAIL sim_done: got %0b exp 1", wr_done); else pass_cnt++;
        total_cnt++; if (dout !== 8'h11) $display("FAIL sim_dout: got %0h exp 11", dout); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL sim_count: got %0d exp 1", count); else pass_cnt++;
`ifdef RAM_AUTO_INC_EN
        total_cnt++; if (addr !== 4'd6) $display("FAIL sim_addr: got %0h exp 6", addr); else pass_cnt++;
`else
        total_cnt++; if (addr !== 4'd5) $display("FAIL sim_addr: got %0h exp 5", addr); else pass_cnt++;
`endif
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL sim_busy_after: got %0b exp 0", busy); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL sim_done_after: got %0b exp 0", wr_done); else pass_cnt++;
        total_cnt++; if (addr !== exp_addr) $display("FAIL sim_addr_after: got %0h exp %0h", addr, exp_addr); else pass_cnt++;
        total_cnt++; if (dout !== exp_rd(exp_addr)) $display("FAIL sim_dout_after: got %0h exp %0h", dout, exp_rd(exp_addr)); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 5'd1) $display("FAIL sim_count_after: got %0d exp 1", count); else pass_cnt++;
        goto_addr(4'd5);
        total_cnt++; if (dout !== 8'h11) $display("FAIL sim_mem5: got %0h exp 11", dout); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        goto_addr(4'd3);
        din   = 8'h77;
        pulse = 2'b10;
        tick();
        pulse = 2'b00;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rm_busy_wr: got %0b exp 1", busy); else pass_cnt++;
        clr_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %0b exp 0", busy); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL rm_count: got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL rm_full: got %0b exp 0", full); else pass_cnt++;
        total_cnt++; if (addr !== 4'd0) $display("FAIL rm_addr: got %0h exp 0", addr); else pass_cnt++;
        total_cnt++; if (wr_done !== 1'b0) $display("FAIL rm_done: got %0b exp 0", wr_done); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        goto_addr(4'd3);
        tick();
        total_cnt++; if (dout !== 8'h00) $display("FAIL rm_dout3: got %0h exp 0", dout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy_idle: got %0b exp 0", busy); else pass_cnt++;
        write_seq(8'h42);
        total_cnt++; if (dout !== 8'h42) $display("FAIL rm_rewrite_dout: got %0h exp 42", dout); else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL rm_rewrite_count: got %0d exp 1", count); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clr_n = 1'b0;
        pulse = 2'b00;
        din   = 8'h00;
        model_reset();
        test_reset();
        test_write_timing();
        test_step_wrap();
        test_overwrite_fill();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
